// File: rtl/fp_soc_keycode_pkg.sv
// Shared constants for the keycode FIFO slave: register word addresses and
// the bit positions inside the STATUS and CONTROL registers.
package fp_soc_keycode_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_PEEK    = 2'd3;

  localparam int ST_EMPTY = 8;
  localparam int ST_FULL  = 9;
  localparam int ST_OVF   = 10;

  localparam int CT_FLUSH   = 0;
  localparam int CT_OVF_CLR = 1;
  localparam int CT_IRQ_EN  = 2;

endpackage

// File: rtl/fp_soc_keycode_fifo_mem.sv
// First-word-fall-through storage for the keycode FIFO: array, wrapping
// pointers and an occupancy counter. Flush overrides any push or pop.
module fp_soc_keycode_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A push into a full FIFO is only taken when the head leaves in the same cycle
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);

  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fp_soc_keycode_fifo.sv
// Avalon-MM keycode port with FIFO and valid/ready drain stream.
// Define KEYCODE_FIFO_IRQ_EN to add the irq output and CONTROL irq_en bit.
module fp_soc_keycode_fifo
  import fp_soc_keycode_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
`ifdef KEYCODE_FIFO_IRQ_EN
  output logic              irq,
`endif
  input  logic              out_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic              push;
  logic              pop;
  logic              flush;
  logic              ovf_clr;
  logic              ctrl_wr;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              irq_en_rd;
  logic              unused_wdata;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] last_written;

  assign wr_en   = chipselect & ~write_n;
  assign push    = wr_en & (address == ADDR_DATA);
  assign ctrl_wr = wr_en & (address == ADDR_CONTROL);
  assign flush   = ctrl_wr & writedata[CT_FLUSH];
  assign ovf_clr = ctrl_wr & writedata[CT_OVF_CLR];

  assign out_valid    = ~empty;
  assign out_data     = head;
  assign pop          = out_valid & out_ready;
  assign unused_wdata = ^writedata;

  fp_soc_keycode_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (writedata[DATA_W-1:0]),
    .rdata (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  // Overflow only when a write is really lost; a set beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      last_written <= '0;
      overflow     <= 1'b0;
    end else begin
      if (push) last_written <= writedata[DATA_W-1:0];
      if (push && full && !pop && !flush) overflow <= 1'b1;
      else if (ovf_clr)                   overflow <= 1'b0;
    end
  end

`ifdef KEYCODE_FIFO_IRQ_EN
  logic irq_en;

  always_ff @(posedge clk) begin
    if (reset)        irq_en <= 1'b0;
    else if (ctrl_wr) irq_en <= writedata[CT_IRQ_EN];
  end

  assign irq_en_rd = irq_en;
  assign irq       = irq_en & ~empty;
`else
  assign irq_en_rd = 1'b0;
`endif

  always_comb begin
    readdata = '0;
    if (chipselect) begin
      case (address)
        ADDR_DATA:    readdata = 32'(last_written);
        ADDR_STATUS: begin
          readdata[7:0]    = 8'(count);
          readdata[ST_EMPTY] = empty;
          readdata[ST_FULL]  = full;
          readdata[ST_OVF]   = overflow;
        end
        ADDR_CONTROL: readdata[CT_IRQ_EN] = irq_en_rd;
        default:      readdata = 32'(head);
      endcase
    end
  end

endmodule
